// File: rtl/dram_reader_pkg.sv
// Shared definitions for the DRAM burst reader: FSM state encoding and
// default interface widths.
package dram_reader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      OUT  = 2'd2
   } state_e;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_OUT_BYTES  = 4;
   localparam int DEF_LEN_WIDTH  = 16;

endpackage

// File: rtl/simple_memory.sv
// Single-port byte memory with one-cycle registered read; reset loads
// every location with the low bits of its own address.
module simple_memory #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] dout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= DATA_WIDTH'(i);
         end
         dout_q <= '0;
      end else begin
         if (we) begin
            mem_q[addr] <= din;
         end
         dout_q <= mem_q[addr];
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/dram_burst_reader.sv
// Reads cmd_len bytes from cmd_addr on a one-cycle-latency memory and packs
// them little-endian into OUT_BYTES-wide words on a valid/ready stream.
module dram_burst_reader
   import dram_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int OUT_BYTES  = DEF_OUT_BYTES,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [ADDR_WIDTH-1:0]           cmd_addr,
   input  logic [LEN_WIDTH-1:0]            cmd_len,
   output logic                            mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_din,
   input  logic [DATA_WIDTH-1:0]           mem_dout,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [OUT_BYTES*DATA_WIDTH-1:0] out_data,
   output logic                            out_last,
   output logic                            busy,
   output logic                            done
);
   localparam int LANE_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
   localparam int WL_W   = $clog2(OUT_BYTES + 1);
   localparam int WORD_W = OUT_BYTES * DATA_WIDTH;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
   localparam logic [LANE_W-1:0]     LANE_ONE = LANE_W'(1);
   localparam logic [WL_W-1:0]       WL_ONE   = WL_W'(1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [WL_W-1:0]       word_left_q, word_left_d;
   logic [LANE_W-1:0]     lane_q, lane_d;
   logic                  cap_vld_q, cap_vld_d;
   logic [LANE_W-1:0]     cap_lane_q, cap_lane_d;
   logic [WORD_W-1:0]     data_q, data_d;
   logic                  done_q, done_d;

   // Bytes to issue for the next word: a full word or whatever remains.
   function automatic logic [WL_W-1:0] word_size(input logic [LEN_WIDTH-1:0] len);
      if (len >= LEN_WIDTH'(OUT_BYTES)) begin
         return WL_W'(OUT_BYTES);
      end
      return len[WL_W-1:0];
   endfunction

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      word_left_d = word_left_q;
      lane_d      = lane_q;
      cap_vld_d   = 1'b0;
      cap_lane_d  = cap_lane_q;
      data_d      = data_q;
      done_d      = 1'b0;

      // Read data returns one cycle after its address was issued.
      for (int i = 0; i < OUT_BYTES; i++) begin
         if (cap_vld_q && (cap_lane_q == LANE_W'(i))) begin
            data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_dout;
         end
      end

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = FILL;
                  addr_d      = cmd_addr;
                  rem_d       = cmd_len;
                  word_left_d = word_size(cmd_len);
                  lane_d      = '0;
                  data_d      = '0;
               end
            end
         end
         FILL: begin
            if (word_left_q != '0) begin
               cap_vld_d   = 1'b1;
               cap_lane_d  = lane_q;
               lane_d      = lane_q + LANE_ONE;
               word_left_d = word_left_q - WL_ONE;
               rem_d       = rem_q - LEN_ONE;
               // The last issued address stays on the bus until the next word.
               if (word_left_q != WL_ONE) begin
                  addr_d = addr_q + ADDR_ONE;
               end
            end else begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               if (rem_q != '0) begin
                  state_d     = FILL;
                  addr_d      = addr_q + ADDR_ONE;
                  word_left_d = word_size(rem_q);
                  lane_d      = '0;
                  data_d      = '0;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         word_left_q <= '0;
         lane_q      <= '0;
         cap_vld_q   <= 1'b0;
         cap_lane_q  <= '0;
         data_q      <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         word_left_q <= word_left_d;
         lane_q      <= lane_d;
         cap_vld_q   <= cap_vld_d;
         cap_lane_q  <= cap_lane_d;
         data_q      <= data_d;
         done_q      <= done_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == OUT);
   assign out_last  = (state_q == OUT) && (rem_q == '0);
   assign out_data  = data_q;
   assign mem_addr  = addr_q;
   assign mem_we    = 1'b0;
   assign mem_din   = '0;
   assign done      = done_q;

endmodule
